// File: rtl/vedic_pkg.sv
// Shared widths, pipeline stage records and carry-lookahead helpers for the
// 8x8 Vedic multiply-accumulate pipeline.
package vedic_pkg;

   localparam int WIDTH  = 8;
   localparam int ACC_W  = 24;
   localparam int PROD_W = 2 * WIDTH;
   localparam int HALF   = WIDTH / 2;

   typedef struct packed {
      logic             valid;
      logic             clr;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   // The four half-width cross products of the operand pair.
   typedef struct packed {
      logic              valid;
      logic              clr;
      logic [WIDTH-1:0]  ll;
      logic [WIDTH-1:0]  lh;
      logic [WIDTH-1:0]  hl;
      logic [WIDTH-1:0]  hh;
   } s2_t;

   typedef struct packed {
      logic              valid;
      logic [PROD_W-1:0] prod;
   } s3_t;

   // 4-bit carry-lookahead adder: returns {carry_out, sum}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   // Sum only, for call sites where the carry-out is provably zero.
   function automatic logic [3:0] cla4_s(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
      logic [4:0] r;
      r = cla4(x, y, cin);
      return r[3:0];
   endfunction

   // 16-bit adder as four chained 4-bit lookahead blocks; carry-out dropped.
   function automatic logic [15:0] cla16(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] s;
      logic [4:0]  r;
      logic        c;
      c = 1'b0;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         r          = cla4(x[4*i +: 4], y[4*i +: 4], c);
         s[4*i +: 4] = r[3:0];
         c          = r[4];
      end
      return s;
   endfunction

endpackage

// File: rtl/vedicmult_2bit.sv
// 2x2 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier cell.
module vedicmult_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   logic cross_c;

   assign cross_c = a[1] & b[0] & a[0] & b[1];
   assign p[0]    = a[0] & b[0];
   assign p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
   assign p[2]    = (a[1] & b[1]) ^ cross_c;
   assign p[3]    = a[1] & b[1] & cross_c;

endmodule

// File: rtl/vedicmult_4bit.sv
// Combinational 4x4 unsigned Vedic multiplier from four 2x2 cells whose
// partial products are merged with 4-bit carry-lookahead adders.
module vedicmult_4bit
   import vedic_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [3:0] q0;
   logic [3:0] q1;
   logic [3:0] q2;
   logic [3:0] q3;
   logic [3:0] s_a;
   logic [3:0] s_b;
   logic       c_a;
   logic       c_b;
   logic [4:0] mid;
   logic [3:0] hi;

   vedicmult_2bit u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
   vedicmult_2bit u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
   vedicmult_2bit u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
   vedicmult_2bit u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

   // Middle column: q1 + q2 + upper half of q0 never exceeds 21, so at most
   // one of the two carries can be set.
   assign {c_a, s_a} = cla4(q1, q2, 1'b0);
   assign {c_b, s_b} = cla4(s_a, {2'b00, q0[3:2]}, 1'b0);
   assign mid        = {c_a | c_b, s_b};
   assign hi         = cla4_s(q3, {1'b0, mid[4:2]}, 1'b0);

   assign p = {hi, mid[1:0], q0[1:0]};

endmodule

// File: rtl/vedic_mac8_pipe.sv
// Three-stage pipelined 8x8 unsigned Vedic multiply-accumulate with a
// valid/ready handshake; all stages advance together on a global enable.
module vedic_mac8_pipe
   import vedic_pkg::*;
#(
   parameter int WIDTH = vedic_pkg::WIDTH,
   parameter int ACC_W = vedic_pkg::ACC_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 clr_acc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic [ACC_W-1:0]     acc,
   output logic                 acc_ovf
);

   s1_t              s1_q, s1_d;
   s2_t              s2_q, s2_d;
   s3_t              s3_q, s3_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic             en;
   logic [WIDTH-1:0] pp [4];
   logic [15:0]      mid_sum;
   logic [15:0]      shift_sum;
   logic [15:0]      prod_sum;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_sum;
   logic             acc_carry;

   assign en        = ~s3_q.valid | out_ready;
   assign in_ready  = en;
   assign out_valid = s3_q.valid;
   assign prod      = s3_q.prod;
   assign acc       = acc_q;
   assign acc_ovf   = ovf_q;

   // Cell index bit 1 selects the half of a, bit 0 the half of b:
   // 0 = ll, 1 = lh, 2 = hl, 3 = hh.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cell
         vedicmult_4bit u_cell (
            .a (s1_q.a[HALF*(gi/2) +: HALF]),
            .b (s1_q.b[HALF*(gi%2) +: HALF]),
            .p (pp[gi])
         );
      end
   endgenerate

   always_comb begin
      mid_sum   = cla16({8'h00, s2_q.lh}, {8'h00, s2_q.hl});
      shift_sum = cla16({8'h00, s2_q.ll}, mid_sum << 4);
      prod_sum  = cla16(shift_sum, {8'h00, s2_q.hh} << 8);
   end

   // Accumulator adder: nibble-wide lookahead blocks rippling a block carry.
   always_comb begin
      logic [4:0] r;
      logic       c;
      acc_base = s2_q.clr ? '0 : acc_q;
      prod_ext = ACC_W'(prod_sum);
      acc_sum  = '0;
      c        = 1'b0;
      for (int i = 0; i < ACC_W / 4; i++) begin
         r                 = cla4(acc_base[4*i +: 4], prod_ext[4*i +: 4], c);
         acc_sum[4*i +: 4] = r[3:0];
         c                 = r[4];
      end
      acc_carry = c;
   end

   always_comb begin
      s1_d  = s1_q;
      s2_d  = s2_q;
      s3_d  = s3_q;
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (en) begin
         s1_d.valid = in_valid;
         s1_d.clr   = clr_acc;
         s1_d.a     = a;
         s1_d.b     = b;

         s2_d.valid = s1_q.valid;
         s2_d.clr   = s1_q.clr;
         s2_d.ll    = pp[0];
         s2_d.lh    = pp[1];
         s2_d.hl    = pp[2];
         s2_d.hh    = pp[3];

         s3_d.valid = s2_q.valid;
         // Bubbles leave the visible result and accumulator untouched.
         if (s2_q.valid) begin
            s3_d.prod = prod_sum;
            acc_d     = acc_sum;
            ovf_d     = (s2_q.clr ? 1'b0 : ovf_q) | acc_carry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         s3_q  <= s3_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: doc/vedic_mac8_pipe.md
Name: vedic_mac8_pipe

Overview:
- 3-stage pipelined 8x8 unsigned Vedic multiply-accumulate; the sequential stage that consumes the 2-bit Vedic multiplier cells.
- Partial products come from 4x4 Vedic cells (each built from four 2-bit Vedic multipliers) and are combined with carry-lookahead adders.
- The product and a running accumulator go downstream under a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width; only 8 supported in this revision.
- ACC_W, 24, accumulator width; must be at least 2*WIDTH.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- clr_acc  input  1  sampled with a/b; this item starts a new accumulation
- out_valid  output  1  prod/acc/acc_ovf valid
- out_ready  input  1  downstream accepts result
- prod  output  2*WIDTH  a*b of the item at the output
- acc  output  ACC_W  running sum including prod
- acc_ovf  output  1  sticky accumulator wrap flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits = 0, so in_ready = 1 and out_valid = 0;
  - prod = 0, acc = 0, acc_ovf = 0, all pipeline data registers = 0.
  - Reset mid-operation discards in-flight items; nothing is emitted afterwards.
- Global enable en = ~out_valid | out_ready; in_ready = en (combinational).
- Input transfer: in_valid & in_ready. The S1 valid bit loads in_valid on en.
- Stages, all advancing together when en = 1:
  - S1: register a, b, clr_acc.
  - S2: four 4x4 Vedic products registered as ll = aL*bL, lh = aL*bH, hl = aH*bL, hh = aH*bH (8 bits each).
  - S3: prod = ll + ((lh + hl) << 4) + (hh << 8), 16 bits, via CLA.
  - Valid bits shift S1 -> S2 -> S3 with the data; bubbles propagate as invalid.
- Latency: 3 cycles from accepted input to out_valid when unstalled. Throughput: 1 item per cycle.
- Stall: out_valid = 1 and out_ready = 0 -> every stage holds, including prod, acc and acc_ovf. in_ready = 0.
- Accumulator update, only when a valid item loads into S3:
  - base = 0 if that item's clr_acc = 1, else the current acc;
  - acc = (base + zero-extended prod) mod 2^ACC_W;
  - acc_ovf = (clr_acc ? 0 : acc_ovf) | carry-out of that add.
- Bubbles loading into S3 leave acc, acc_ovf and prod unchanged.
- Output hold: prod/acc remain stable while out_valid = 1 and out_ready = 0.
- Arithmetic: all unsigned. Product exact (max 0xFE01). The accumulator wraps with no saturation.
- Simultaneous input accept and output drain in the same cycle is legal and gives a full-rate pipeline.

Decomposition:
- Package vedic_pkg:
  - WIDTH and ACC_W defaults;
  - PROD_W = 2*WIDTH;
  - HALF = WIDTH/2;
  - a typedef for the S1/S2/S3 stage record (valid, clr flag, data fields).
- One sub-module, vedicmult_4bit:
  - combinational 4x4 Vedic multiplier;
  - built from four existing 2-bit Vedic multiplier instances plus a 4-bit CLA;
  - instantiated four times in S2.
- The 16-bit combine adders are CLA chains inside the top.

Test Plan:
- Reset then a=200, b=150, clr_acc=1, out_ready=1 -> 3 cycles later out_valid=1, prod=0x7530, acc=30000, acc_ovf=0.
- Back-to-back a=10,b=10,clr=1 then a=20,b=20,clr=0 then a=255,b=255,clr=1 -> prod 100, 400, 65025 on consecutive cycles; acc 100, 500, 65025.
- Stall: three items in flight, out_ready=0 -> in_ready=0, outputs frozen for 5 cycles; out_ready=1 -> items drain in order with no loss or duplication.
- Overflow: 255*255 with clr on the first item, then 258 more with clr=0 -> after item 258 acc=16776450, acc_ovf=0; after item 259 acc=64259, acc_ovf=1; next item with clr=1 clears acc_ovf.
- Bubbles: in_valid toggling 1,0,1 -> out_valid pattern 1,0,1 three cycles later; acc unchanged across the bubble.
- rst_n asserted mid-stream with 2 items in flight -> out_valid=0, acc=0, acc_ovf=0 immediately; no stale output after release.
